// File: rtl/note_sequencer.sv
// Playback sequencer: fetches {note, duration} words from song memory and plays each note for
// duration ticks followed by a silent gap. Define SEQ_LOOP_EN to restart the song at its end marker.
module note_sequencer #(
  parameter int DATA_WIDTH = 16,
  parameter int NOTE_WIDTH = 6,
  parameter int DUR_WIDTH  = 10,
  parameter int TICK_DIV   = 100000,
  parameter int GAP_TICKS  = 20
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  pause,
  output logic                  read_en,
  output logic                  read_rst,
  input  logic [DATA_WIDTH-1:0] mem_data,
  input  logic                  mem_ready,
  output logic [NOTE_WIDTH-1:0] note_out,
  output logic                  note_valid,
  output logic                  playing,
  output logic                  done,
  output logic [7:0]            note_index,
  output logic [2:0]            state_dbg
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] FETCH = 3'd1;
  localparam logic [2:0] WAIT  = 3'd2;
  localparam logic [2:0] PLAY  = 3'd3;
  localparam logic [2:0] GAP   = 3'd4;
  localparam logic [2:0] DONE  = 3'd5;

  localparam int PRE_W = $clog2(TICK_DIV);
  localparam int GAP_W = (GAP_TICKS > 1) ? $clog2(GAP_TICKS + 1) : 1;
  localparam int CNT_W = (DUR_WIDTH > GAP_W) ? DUR_WIDTH : GAP_W;
  localparam logic [PRE_W-1:0] PRE_MAX  = PRE_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_TICKS);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [2:0]            state;
  logic [2:0]            state_nxt;
  logic [NOTE_WIDTH-1:0] note_q;
  logic [CNT_W-1:0]      tick_left;
  logic [PRE_W-1:0]      presc;
  logic                  read_rst_q;
  logic                  done_q;

  logic                  rewind;
  logic                  finish_pass;
  logic                  clr_index;
  logic                  latch_word;
  logic                  tick;
  logic                  last_tick;

  logic [NOTE_WIDTH-1:0] word_note;
  logic [DUR_WIDTH-1:0]  word_dur;
  logic [DUR_WIDTH-1:0]  dur_eff;

  assign word_note = mem_data[DATA_WIDTH-1 -: NOTE_WIDTH];
  assign word_dur  = mem_data[DUR_WIDTH-1:0];
  // A zero duration still sounds for one tick so every note is audible.
  assign dur_eff   = (word_dur == '0) ? DUR_WIDTH'(1) : word_dur;

  // The prescaler only advances while timing a note or a gap and not paused.
  assign tick      = (state == PLAY || state == GAP) && !pause && (presc == PRE_MAX);
  assign last_tick = tick && (tick_left == CNT_ONE);

  // Memory handshake: read_en is a single-cycle request issued from FETCH; the sequencer then
  // sits in WAIT and consumes mem_data on the first cycle mem_ready is high. mem_ready seen in
  // any other state is ignored, so at most one request is ever outstanding.
  always_comb begin
    state_nxt   = state;
    rewind      = 1'b0;
    finish_pass = 1'b0;
    clr_index   = 1'b0;
    latch_word  = 1'b0;
    if (stop) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state_nxt = FETCH;
            rewind    = 1'b1;
            clr_index = 1'b1;
          end
        end
        FETCH: state_nxt = WAIT;
        WAIT: begin
          if (mem_ready) begin
            if (mem_data == '0) begin
              finish_pass = 1'b1;
`ifdef SEQ_LOOP_EN
              state_nxt   = FETCH;
              rewind      = 1'b1;
`else
              state_nxt   = DONE;
`endif
            end else begin
              latch_word = 1'b1;
              state_nxt  = PLAY;
            end
          end
        end
        PLAY: begin
          if (last_tick) begin
            if (GAP_TICKS == 0) state_nxt = FETCH;
            else                state_nxt = GAP;
          end
        end
        GAP: begin
          if (last_tick) state_nxt = FETCH;
        end
        DONE: begin
          if (start) begin
            state_nxt = FETCH;
            rewind    = 1'b1;
            clr_index = 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      note_q     <= '0;
      tick_left  <= '0;
      presc      <= '0;
      read_rst_q <= 1'b0;
      done_q     <= 1'b0;
      note_index <= 8'd0;
    end else begin
      state      <= state_nxt;
      read_rst_q <= rewind;
      done_q     <= finish_pass;

      if (clr_index)       note_index <= 8'd0;
      else if (latch_word) note_index <= note_index + 8'd1;

      if (latch_word) begin
        note_q    <= word_note;
        tick_left <= CNT_W'(dur_eff);
        presc     <= '0;
      end else if ((state == PLAY || state == GAP) && !pause && !stop) begin
        if (presc == PRE_MAX) begin
          presc <= '0;
          // Leaving PLAY preloads the gap length; the wrapped prescaler starts the gap cleanly.
          if (tick_left == CNT_ONE) tick_left <= GAP_LOAD;
          else                      tick_left <= tick_left - CNT_ONE;
        end else begin
          presc <= presc + PRE_W'(1);
        end
      end
    end
  end

  assign read_en    = (state == FETCH);
  assign read_rst   = read_rst_q;
  assign done       = done_q;
  assign note_out   = (state == PLAY) ? note_q : '0;
  assign note_valid = (state == PLAY) && (note_q != '0);
  assign playing    = (state != IDLE) && (state != DONE);
  assign state_dbg  = state;

endmodule
